cheshire_rst_seq: RTL and testbench



---
 rtl/cheshire_rst_seq_pkg.sv | 19 +
 rtl/cheshire_rst_seq_debounce.sv | 52 +++++
 rtl/cheshire_rst_seq.sv | 143 ++++++++++++++
 tb/tb_cheshire_rst_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheshire_rst_seq_pkg.sv
// Shared types for the FPGA reset/boot sequencer; ILA decode and the bench use the same state enum.
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
package cheshire_rst_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    DDR_RST    = 3'd1,
    WAIT_CALIB = 3'd2,
    SOC_HOLD   = 3'd3,
    RUN        = 3'd4
  } rst_seq_state_e;

  // Larger of two cycle counts, used to size the shared phase counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cheshire_rst_seq_debounce.sv
// Debounces a synchronized level; emits a one-cycle pulse on each accepted rising edge.
// Latency: Cycles cycles of stable input before q_o follows; rise_o coincides with q_o rising.
// Backpressure: none; level in, level/pulse out.
module cheshire_rst_seq_debounce #(
  parameter int unsigned Cycles = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  localparam int unsigned CntW = $clog2(Cycles) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);

  logic            level_d, level_q;
  logic            rise_d, rise_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  // Count consecutive cycles the input disagrees with the accepted level; accept on the last one.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (d_i != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = d_i;
        rise_d  = d_i;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q_o    = level_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/cheshire_rst_seq.sv
// Reset/boot sequencer: clock lock -> DRAM reset -> calibration (with retry) -> SoC hold -> run.
// Latency: 2-cycle synchronizers on async inputs, then one edge for the FSM to react.
// Backpressure: none; all inputs are levels, restarts take effect on the next edge.
module cheshire_rst_seq
  import cheshire_rst_seq_pkg::*;
#(
  parameter bit          UseDdr         = 1'b1,
  parameter int unsigned DebounceCycles = 50000,
  parameter int unsigned HoldCycles     = 1024,
  parameter int unsigned CalibTimeout   = 2**24
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_rst_i,
  input  logic       vio_rst_i,
  input  logic       clk_locked_i,
  input  logic       ddr_calib_done_i,
  input  logic       test_mode_i,
  input  logic [1:0] boot_mode_i,
  output logic       soc_rst_no,
  output logic       ddr_rst_o,
  output logic [1:0] boot_mode_o,
  output logic       calib_err_o,
  output logic [2:0] state_o
);

  localparam int unsigned CntW = $clog2(max_u(HoldCycles, CalibTimeout)) + 1;
  localparam logic [CntW-1:0] HoldLast  = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] CalibLast = CntW'(CalibTimeout - 1);
  localparam logic [CntW-1:0] CntMax    = '1;

  // Synchronizer bit order: {boot_mode[1:0], calib_done, locked, button}.
  logic [4:0] sync1_d, sync1_q, sync2_d, sync2_q;
  logic       btn_s, lock_s, calib_s;
  logic [1:0] boot_s;
  logic       press;

  rst_seq_state_e  state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            err_d, err_q;
  logic [1:0]      boot_d, boot_q;
  logic            restart;
  rst_seq_state_e  entry_state;

  // Two-stage synchronizer shift for all asynchronous inputs.
  always_comb begin
    sync1_d = {boot_mode_i, ddr_calib_done_i, clk_locked_i, btn_rst_i};
    sync2_d = sync1_q;
  end

  assign btn_s   = sync2_q[0];
  assign lock_s  = sync2_q[1];
  assign calib_s = sync2_q[2];
  assign boot_s  = sync2_q[4:3];

  cheshire_rst_seq_debounce #(
    .Cycles (DebounceCycles)
  ) i_debounce (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (btn_s),
    .q_o    (),
    .rise_o (press)
  );

  assign entry_state = UseDdr ? DDR_RST : SOC_HOLD;

  // Next state: phase transitions, then restart events override (lock loss before press/VIO).
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    boot_d  = boot_q;
    restart = 1'b0;
    case (state_q)
      WAIT_LOCK:  if (lock_s) state_d = entry_state;
      DDR_RST:    if (cnt_q == HoldLast) state_d = WAIT_CALIB;
      WAIT_CALIB: begin
        if (calib_s) begin
          state_d = SOC_HOLD;
        end else if (cnt_q == CalibLast) begin
          state_d = DDR_RST;
          err_d   = 1'b1;
        end
      end
      SOC_HOLD: begin
        if (cnt_q == HoldLast) begin
          state_d = RUN;
          boot_d  = boot_s;
        end
      end
      RUN:        ;
      default:    state_d = WAIT_LOCK;
    endcase
    if (state_q != WAIT_LOCK) begin
      if (!lock_s) begin
        state_d = WAIT_LOCK;
        restart = 1'b1;
      end else if (press || vio_rst_i) begin
        state_d = entry_state;
        restart = 1'b1;
      end
      // A restart pre-empts whatever phase transition was pending this cycle.
      if (restart) begin
        err_d  = err_q;
        boot_d = boot_q;
      end
    end
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Sequencer and synchronizer registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      boot_q  <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      boot_q  <= boot_d;
    end
  end

  // Test mode hands SoC reset straight to the global reset for scan.
  assign soc_rst_no  = test_mode_i ? rst_ni : (state_q == RUN);
  assign ddr_rst_o   = UseDdr && ((state_q == WAIT_LOCK) || (state_q == DDR_RST));
  assign boot_mode_o = boot_q;
  assign calib_err_o = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_cheshire_rst_seq.sv
// Bench for cheshire_rst_seq with short debounce/hold/timeout values.
// Latency: drives and samples 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_cheshire_rst_seq;
  import cheshire_rst_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       btn = 1'b0, vio = 1'b0, lock = 1'b0, calib = 1'b0, tmode = 1'b0;
  logic [1:0] boot_i = 2'b00;
  logic       soc_rst_no, ddr_rst_o, calib_err_o;
  logic [1:0] boot_mode_o;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  // Expected {soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o}.
  logic [7:0] exp_q[$];
  // Expected phase lengths in cycles.
  int dur_q[$];

  always #5 clk = ~clk;

  cheshire_rst_seq #(
    .UseDdr         (1'b1),
    .DebounceCycles (4),
    .HoldCycles     (8),
    .CalibTimeout   (100)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .btn_rst_i        (btn),
    .vio_rst_i        (vio),
    .clk_locked_i     (lock),
    .ddr_calib_done_i (calib),
    .test_mode_i      (tmode),
    .boot_mode_i      (boot_i),
    .soc_rst_no       (soc_rst_no),
    .ddr_rst_o        (ddr_rst_o),
    .boot_mode_o      (boot_mode_o),
    .calib_err_o      (calib_err_o),
    .state_o          (state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state_o == target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic measure(input logic [2:0] target, output int n);
    n = 0;
    while (state_o == target && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic pulse_vio();
    vio = 1'b1;
    tick();
    vio = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_ni = 1'b0;
    exp_q.push_back({1'b0, 1'b1, 2'b00, 1'b0, 3'd0});
    tick();
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o} !== e) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b",
               {soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o}, e);
    end
  endtask

  task automatic test_power_up();
    bit ok;
    int n, d;
    logic [7:0] e;
    rst_ni = 1'b1;
    boot_i = 2'b10;
    repeat (10) tick();
    lock = 1'b1;
    dur_q.push_back(8);
    dur_q.push_back(8);
    exp_q.push_back({1'b1, 1'b0, 2'b10, 1'b0, 3'd4});
    wait_state(3'd1, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pu_reach_ddr_rst: state %0d expected 1", state_o); end
    measure(3'd1, n);
    d = dur_q.pop_front();
    checks++;
    if (n !== d) begin errors++; $display("FAIL pu_ddr_hold_len: got %0d expected %0d", n, d); end
    checks++;
    if ({ddr_rst_o, state_o} !== {1'b0, 3'd2}) begin
      errors++;
      $display("FAIL pu_ddr_release: ddr %b state %0d expected 0/2", ddr_rst_o, state_o);
    end
    repeat (10) tick();
    calib = 1'b1;
    wait_state(3'd3, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pu_reach_soc_hold: state %0d expected 3", state_o); end
    measure(3'd3, n);
    d = dur_q.pop_front();
    checks++;
    if (n !== d) begin errors++; $display("FAIL pu_soc_hold_len: got %0d expected %0d", n, d); end
    e = exp_q.pop_front();
    checks++;
    if ({soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o} !== e) begin
      errors++;
      $display("FAIL pu_run_outputs: got %b expected %b",
               {soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o}, e);
    end
  endtask

  task automatic test_calib_timeout();
    bit ok;
    int n, d;
    logic [7:0] e;
    calib = 1'b0;
    repeat (5) tick();
    checks++;
    if ({soc_rst_no, state_o} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL calib_drop_in_run: soc %b state %0d expected 1/4", soc_rst_no, state_o);
    end
    dur_q.push_back(100);
    dur_q.push_back(8);
    exp_q.push_back({1'b1, 1'b0, 2'b10, 1'b1, 3'd4});
    pulse_vio();
    wait_state(3'd2, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_reach_wait_calib: state %0d expected 2", state_o); end
    measure(3'd2, n);
    d = dur_q.pop_front();
    checks++;
    if (n !== d) begin errors++; $display("FAIL to_timeout_len: got %0d expected %0d", n, d); end
    checks++;
    if ({ddr_rst_o, calib_err_o, state_o} !== {1'b1, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL to_retry: ddr %b err %b state %0d expected 1/1/1",
               ddr_rst_o, calib_err_o, state_o);
    end
    calib = 1'b1;
    measure(3'd1, n);
    d = dur_q.pop_front();
    checks++;
    if (n !== d) begin errors++; $display("FAIL to_retry_hold_len: got %0d expected %0d", n, d); end
    wait_state(3'd4, 30, ok);
    e = exp_q.pop_front();
    checks++;
    if ({soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o} !== e) begin
      errors++;
      $display("FAIL to_run_sticky_err: got %b expected %b",
               {soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o}, e);
    end
  endtask

  task automatic test_debounce();
    int left_run, restarts, low, d;
    logic [2:0] prev;
    dur_q.push_back(0);
    dur_q.push_back(1);
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    left_run = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state_o != 3'd4) left_run++;
    end
    d = dur_q.pop_front();
    checks++;
    if (left_run !== d) begin errors++; $display("FAIL db_glitch: left RUN %0d cycles expected %0d", left_run, d); end
    restarts = 0;
    low = 0;
    prev = state_o;
    btn = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i == 20) btn = 1'b0;
      tick();
      if (prev != 3'd1 && state_o == 3'd1) restarts++;
      if (!soc_rst_no) low++;
      prev = state_o;
    end
    d = dur_q.pop_front();
    checks++;
    if (restarts !== d) begin errors++; $display("FAIL db_held_restarts: got %0d expected %0d", restarts, d); end
    checks++;
    if (low < 16) begin errors++; $display("FAIL db_soc_low_len: got %0d expected >=16", low); end
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL db_back_to_run: state %0d expected 4", state_o); end
  endtask

  task automatic test_lock_loss();
    bit ok;
    logic [7:0] e;
    exp_q.push_back({1'b0, 1'b1, 2'b10, 1'b1, 3'd0});
    lock = 1'b0;
    repeat (3) tick();
    e = exp_q.pop_front();
    checks++;
    if ({soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o} !== e) begin
      errors++;
      $display("FAIL lock_loss: got %b expected %b",
               {soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o}, e);
    end
    boot_i = 2'b01;
    lock = 1'b1;
    wait_state(3'd4, 60, ok);
    checks++;
    if (!ok || boot_mode_o !== 2'b01) begin
      errors++;
      $display("FAIL lock_relock: state %0d boot %b expected 4/01", state_o, boot_mode_o);
    end
  endtask

  task automatic test_boot_mode();
    bit ok;
    int bad;
    logic [7:0] e;
    exp_q.push_back({1'b1, 1'b0, 2'b11, 1'b1, 3'd4});
    boot_i = 2'b11;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (boot_mode_o != 2'b01) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL boot_stable_in_run: %0d cycles changed, expected 0 (now %b)", bad, boot_mode_o); end
    pulse_vio();
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL boot_vio_restart: state %0d expected 1", state_o); end
    wait_state(3'd4, 40, ok);
    e = exp_q.pop_front();
    checks++;
    if ({soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o} !== e) begin
      errors++;
      $display("FAIL boot_after_vio: got %b expected %b",
               {soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o}, e);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] e;
    calib = 1'b0;
    pulse_vio();
    wait_state(3'd2, 20, ok);
    repeat (5) tick();
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL rm_in_wait_calib: state %0d expected 2", state_o); end
    exp_q.push_back({1'b0, 1'b1, 2'b00, 1'b0, 3'd0});
    exp_q.push_back({1'b0, 1'b1, 2'b00, 1'b0, 3'd0});
    rst_ni = 1'b0;
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o} !== e) begin
      errors++;
      $display("FAIL rm_reset_values: got %b expected %b",
               {soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o}, e);
    end
    rst_ni = 1'b1;
    tmode = 1'b1;
    tick();
    checks++;
    if (soc_rst_no !== 1'b1) begin errors++; $display("FAIL tm_follow_high: soc %b expected 1", soc_rst_no); end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (soc_rst_no !== 1'b0) begin errors++; $display("FAIL tm_comb_low: soc %b expected 0", soc_rst_no); end
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o} !== e) begin
      errors++;
      $display("FAIL tm_reset_values: got %b expected %b",
               {soc_rst_no, ddr_rst_o, boot_mode_o, calib_err_o, state_o}, e);
    end
    rst_ni = 1'b1;
    wait_state(3'd1, 20, ok);
    checks++;
    if (!ok || soc_rst_no !== 1'b1) begin
      errors++;
      $display("FAIL tm_fsm_runs: state %0d soc %b expected 1/1", state_o, soc_rst_no);
    end
    tmode = 1'b0;
    #1;
    checks++;
    if (soc_rst_no !== 1'b0) begin errors++; $display("FAIL tm_exit: soc %b expected 0", soc_rst_no); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_calib_timeout();
    test_debounce();
    test_lock_loss();
    test_boot_mode();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
